// File: rtl/controller_reader_if.sv
// Bus between the controller reader and its surroundings: scan request, serial
// controller data, and the generated latch/shift clock plus decoded buttons.
interface controller_reader_if;
    logic       start;
    logic       data1_B;
    logic       data2_B;
    logic       latch;
    logic       ctrl_clk;
    logic [7:0] buttons1;
    logic [7:0] buttons2;
    logic       valid;
    logic       busy;

    // master is the reader itself; slave is the host/connector side
    modport master (
        input  start, data1_B, data2_B,
        output latch, ctrl_clk, buttons1, buttons2, valid, busy
    );
    modport slave (
        output start, data1_B, data2_B,
        input  latch, ctrl_clk, buttons1, buttons2, valid, busy
    );
endinterface

// File: rtl/controller_reader.sv
// Serial game-controller reader: drives latch/shift clock, shifts in two 8-bit
// active-low button streams MSB-first and publishes active-high button bytes.
module controller_reader #(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    controller_reader_if.master bus,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_DONE} state_e;

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  phase_q, phase_d;
    logic [1:0]  sync1_q, sync2_q;
    logic [7:0]  shift1_q, shift1_d, shift2_q, shift2_d;
    logic        latch_q, latch_d, ctrl_clk_q, ctrl_clk_d;
    logic [7:0]  buttons1_q, buttons1_d, buttons2_q, buttons2_d;
    logic        valid_q, valid_d, busy_q, busy_d;
    logic        wrap, sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phase_q    <= '0;
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            shift1_q   <= 8'hFF;
            shift2_q   <= 8'hFF;
            latch_q    <= 1'b0;
            ctrl_clk_q <= 1'b0;
            buttons1_q <= 8'h00;
            buttons2_q <= 8'h00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            sync1_q    <= {sync1_q[0], bus.data1_B};
            sync2_q    <= {sync2_q[0], bus.data2_B};
            shift1_q   <= shift1_d;
            shift2_q   <= shift2_d;
            latch_q    <= latch_d;
            ctrl_clk_q <= ctrl_clk_d;
            buttons1_q <= buttons1_d;
            buttons2_q <= buttons2_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    // LATCH uses phases 0..3; SHIFT uses 0..13 where even = clock high, odd = low
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        sample  = 1'b0;
        wrap    = (cnt_q == CNT_MAX);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                    phase_d = '0;
                end
            end
            S_LATCH: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                if (wrap) begin
                    if (phase_q == 4'd3) begin
                        state_d = S_SHIFT;
                        phase_d = '0;
                        sample  = 1'b1;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
            end
            S_SHIFT: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                if (wrap) begin
                    sample = phase_q[0];
                    if (phase_q == 4'd13) begin
                        state_d = S_DONE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        shift1_d = sample ? {shift1_q[6:0], sync1_q[1]} : shift1_q;
        shift2_d = sample ? {shift2_q[6:0], sync2_q[1]} : shift2_q;
    end

    // Outputs are decoded from the next state so the pins come straight from flops
    always_comb begin
        latch_d    = (state_d == S_LATCH) && (phase_d != 4'd3);
        ctrl_clk_d = ((state_d == S_LATCH) && (phase_d == 4'd1)) ||
                     ((state_d == S_SHIFT) && !phase_d[0]);
        busy_d     = (state_d != S_IDLE);
        valid_d    = (state_d == S_DONE);
        buttons1_d = (state_d == S_DONE) ? ~shift1_d : buttons1_q;
        buttons2_d = (state_d == S_DONE) ? ~shift2_d : buttons2_q;
    end

    assign bus.latch    = latch_q;
    assign bus.ctrl_clk = ctrl_clk_q;
    assign bus.buttons1 = buttons1_q;
    assign bus.buttons2 = buttons2_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign state_o      = state_q;
endmodule
